// File: rtl/vec_pkg.sv
// Shared types and constants for the vector load sequencer.
package vec_pkg;

    localparam int BEAT_W = 128;
    localparam int VREG_W = 512;
    localparam int WORD_W = 32;
    localparam int NBEATS = VREG_W / BEAT_W;

    typedef enum logic [1:0] {
        VL_1   = 2'b00,
        VL_4   = 2'b01,
        VL_16  = 2'b10,
        VL_BAD = 2'b11
    } vl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WRITE
    } state_e;

    // A single 128-bit beat covers both the 1-word and 4-word lengths.
    function automatic logic [2:0] beat_count(input vl_e vl);
        return (vl == VL_16) ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/vec_load_unit_if.sv
// Request, memory and register-file write signals of the load unit.
// Error signals exist only when VLD_BUS_ERR_EN is defined.
interface vec_load_unit_if
    import vec_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_vl;
    logic [4:0]        req_rd;
    logic [ADDR_W-1:0] req_addr;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [BEAT_W-1:0] mem_rsp_data;

    logic              rf_we;
    logic [1:0]        rf_vl;
    logic [4:0]        rf_wa;
    logic [VREG_W-1:0] rf_wd;
    logic              busy;

`ifdef VLD_BUS_ERR_EN
    logic              mem_rsp_err;
    logic              ld_err;

    modport master (
        input  req_valid, req_vl, req_rd, req_addr,
        output req_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output rf_we, rf_vl, rf_wa, rf_wd, busy, ld_err
    );

    modport slave (
        output req_valid, req_vl, req_rd, req_addr,
        input  req_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  rf_we, rf_vl, rf_wa, rf_wd, busy, ld_err
    );
`else
    modport master (
        input  req_valid, req_vl, req_rd, req_addr,
        output req_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rf_we, rf_vl, rf_wa, rf_wd, busy
    );

    modport slave (
        output req_valid, req_vl, req_rd, req_addr,
        input  req_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rf_we, rf_vl, rf_wa, rf_wd, busy
    );
`endif

endinterface

// File: rtl/vld_beat_buffer.sv
// 512-bit beat assembly register. fmt_o is the write-data formatting of the
// buffer contents including any beat written this cycle.
module vld_beat_buffer
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [1:0]        idx_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  vl_e               vl_i,
    input  logic [1:0]        lane_i,
    output logic [VREG_W-1:0] fmt_o
);

    logic [VREG_W-1:0] buf_q;
    logic [VREG_W-1:0] buf_d;

    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
        assign buf_d[gi*BEAT_W +: BEAT_W] =
            clr_i                          ? '0     :
            (wr_i && (idx_i == 2'(gi)))    ? beat_i :
                                             buf_q[gi*BEAT_W +: BEAT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    always_comb begin
        fmt_o = '0;
        case (vl_i)
            VL_16:   fmt_o = buf_d;
            VL_4:    fmt_o[BEAT_W-1:0] = buf_d[BEAT_W-1:0];
            default: fmt_o[WORD_W-1:0] = buf_d[WORD_W*lane_i +: WORD_W];
        endcase
    end

endmodule

// File: rtl/vec_load_unit.sv
// Vector load sequencer: fetches 1 or 4 beats and issues one register-file
// write. Define VLD_BUS_ERR_EN to turn beat errors into an ld_err pulse.
module vec_load_unit
    import vec_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    vec_load_unit_if.master bus
);

    state_e            state_q, state_d;
    vl_e               vl_q, vl_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        beats_q, beats_d;
    logic [2:0]        issued_q, issued_d;
    logic [2:0]        rcvd_q, rcvd_d;
    logic              err_q, err_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic              rf_we_q, rf_we_d;
    logic [1:0]        rf_vl_q, rf_vl_d;
    logic [4:0]        rf_wa_q, rf_wa_d;
    logic [VREG_W-1:0] rf_wd_q, rf_wd_d;
    logic              busy_q, busy_d;
`ifdef VLD_BUS_ERR_EN
    logic              ld_err_q, ld_err_d;
`endif

    logic              rsp_err;
    logic              buf_clr;
    logic              buf_wr;
    logic [VREG_W-1:0] buf_fmt;

`ifdef VLD_BUS_ERR_EN
    assign rsp_err = bus.mem_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    vld_beat_buffer u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (buf_clr),
        .wr_i   (buf_wr),
        .idx_i  (rcvd_q[1:0]),
        .beat_i (bus.mem_rsp_data),
        .vl_i   (vl_q),
        .lane_i (lane_q),
        .fmt_o  (buf_fmt)
    );

    always_comb begin
        state_d         = state_q;
        vl_d            = vl_q;
        rd_d            = rd_q;
        lane_d          = lane_q;
        base_d          = base_q;
        beats_d         = beats_q;
        issued_d        = issued_q;
        rcvd_d          = rcvd_q;
        err_d           = err_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        rf_we_d         = 1'b0;
        rf_vl_d         = rf_vl_q;
        rf_wa_d         = rf_wa_q;
        rf_wd_d         = rf_wd_q;
`ifdef VLD_BUS_ERR_EN
        ld_err_d        = 1'b0;
`endif
        buf_clr         = 1'b0;
        buf_wr          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An illegal length completes the handshake but starts nothing.
                if (bus.req_valid && (vl_e'(bus.req_vl) != VL_BAD)) begin
                    vl_d            = vl_e'(bus.req_vl);
                    rd_d            = bus.req_rd;
                    lane_d          = bus.req_addr[3:2];
                    base_d          = {bus.req_addr[ADDR_W-1:4], 4'b0000};
                    beats_d         = beat_count(vl_e'(bus.req_vl));
                    issued_d        = '0;
                    rcvd_d          = '0;
                    err_d           = 1'b0;
                    buf_clr         = 1'b1;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {bus.req_addr[ADDR_W-1:4], 4'b0000};
                    state_d         = ST_RUN;
                end
            end

            ST_RUN: begin
                if (mem_req_valid_q && bus.mem_req_ready) begin
                    issued_d        = issued_q + 3'd1;
                    mem_req_valid_d = (issued_d < beats_q);
                    mem_req_addr_d  = base_q + ADDR_W'({issued_d, 4'b0000});
                end
                if (bus.mem_rsp_valid && (rcvd_q < beats_q)) begin
                    buf_wr = 1'b1;
                    rcvd_d = rcvd_q + 3'd1;
                    err_d  = err_q | rsp_err;
                    if (rcvd_d == beats_q) begin
                        state_d         = ST_WRITE;
                        mem_req_valid_d = 1'b0;
                        if (err_d) begin
`ifdef VLD_BUS_ERR_EN
                            ld_err_d = 1'b1;
`endif
                        end else begin
                            rf_we_d = 1'b1;
                            rf_vl_d = vl_q;
                            rf_wa_d = rd_q;
                            rf_wd_d = buf_fmt;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            vl_q            <= VL_1;
            rd_q            <= '0;
            lane_q          <= '0;
            base_q          <= '0;
            beats_q         <= '0;
            issued_q        <= '0;
            rcvd_q          <= '0;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            rf_we_q         <= 1'b0;
            rf_vl_q         <= '0;
            rf_wa_q         <= '0;
            rf_wd_q         <= '0;
            busy_q          <= 1'b0;
`ifdef VLD_BUS_ERR_EN
            ld_err_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            vl_q            <= vl_d;
            rd_q            <= rd_d;
            lane_q          <= lane_d;
            base_q          <= base_d;
            beats_q         <= beats_d;
            issued_q        <= issued_d;
            rcvd_q          <= rcvd_d;
            err_q           <= err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            rf_we_q         <= rf_we_d;
            rf_vl_q         <= rf_vl_d;
            rf_wa_q         <= rf_wa_d;
            rf_wd_q         <= rf_wd_d;
            busy_q          <= busy_d;
`ifdef VLD_BUS_ERR_EN
            ld_err_q        <= ld_err_d;
`endif
        end
    end

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_vl         = rf_vl_q;
    assign bus.rf_wa         = rf_wa_q;
    assign bus.rf_wd         = rf_wd_q;
    assign bus.busy          = busy_q;
`ifdef VLD_BUS_ERR_EN
    assign bus.ld_err        = ld_err_q;
`endif

endmodule

// File: tb/tb_vec_load_unit.sv
// Scoreboard bench for vec_load_unit: directed and random loads against a
// queue-based memory and reference model.
module tb_vec_load_unit;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_load_unit_if #(.ADDR_W(32)) bus();

    vec_load_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]   vl;
        logic [4:0]   rd;
        logic [511:0] wd;
        int           lat;
        bit           err;
    } wr_t;

    typedef struct {
        logic [127:0] data;
        bit           err;
        int           due;
    } beat_t;

    wr_t         exp_q[$];
    int          acc_q[$];
    logic [31:0] addr_q[$];
    beat_t       beat_q[$];
    beat_t       pend_q[$];

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    bit          rnd_mode = 1'b0;
    bit          busy_m = 1'b0;
    bit          stall_p = 1'b0;
    logic [31:0] stall_a = '0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // Memory side: drives ready and returns queued beats in order once due.
    initial begin
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
`ifdef VLD_BUS_ERR_EN
        bus.mem_rsp_err   = 1'b0;
`endif
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.mem_req_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = pend_q[0].data;
`ifdef VLD_BUS_ERR_EN
                bus.mem_rsp_err   = pend_q[0].err;
`endif
                void'(pend_q.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
`ifdef VLD_BUS_ERR_EN
                bus.mem_rsp_err   = 1'($urandom_range(0, 1));
`endif
            end
        end
    end

    // Monitor: compares every DUT event against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs",
                {bus.req_ready, bus.mem_req_valid, bus.rf_we, bus.busy,
                 bus.mem_req_addr, bus.rf_vl, bus.rf_wa},
                {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 5'd0});
            chk("reset_wd", bus.rf_wd, '0);
            exp_q.delete();
            acc_q.delete();
            addr_q.delete();
            beat_q.delete();
            busy_m  = 1'b0;
            stall_p = 1'b0;
        end else begin
            chk("busy", bus.busy, busy_m);
            if (bus.rf_we) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("spurious_rf_we", 1'b1, 1'b0);
                end else begin
                    wr_t e;
                    int  a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rf_wa", bus.rf_wa, e.rd);
                    chk("rf_vl", bus.rf_vl, e.vl);
                    chk("rf_wd", bus.rf_wd, e.wd);
                    chk("write_not_error", e.err, 1'b0);
                    if (e.lat >= 0) chk("latency", cyc - a, e.lat);
                end
                busy_m = 1'b0;
            end
`ifdef VLD_BUS_ERR_EN
            if (bus.ld_err) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("spurious_ld_err", 1'b1, 1'b0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    chk("ld_err_expected", e.err, 1'b1);
                end
                busy_m = 1'b0;
            end
`endif
            if (stall_p) begin
                chk("stall_hold", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, stall_a});
            end
            stall_p = bus.mem_req_valid && !bus.mem_req_ready;
            stall_a = bus.mem_req_addr;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (addr_q.size() == 0 || beat_q.size() == 0) begin
                    chk("spurious_mem_req", 1'b1, 1'b0);
                end else begin
                    beat_t b;
                    chk("mem_req_addr", bus.mem_req_addr, addr_q.pop_front());
                    b = beat_q.pop_front();
                    b.due = cyc + 1 + (rnd_mode ? int'($urandom_range(0, 3)) : 0);
                    pend_q.push_back(b);
                end
            end
            if (bus.req_valid && bus.req_ready && bus.req_vl != 2'b11) begin
                acc_q.push_back(cyc);
                busy_m = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected addresses, beats and write bundle from the rules.
    task automatic do_req(input logic [1:0] vl, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [511:0] bb, input logic [3:0] errs, input int lat);
        int  n;
        int  t;
        wr_t e;
        n = (vl == 2'b10) ? 4 : 1;
        if (vl != 2'b11) begin
            e.err = 1'b0;
            for (int i = 0; i < n; i++) begin
                beat_t b;
                addr_q.push_back((addr & 32'hFFFF_FFF0) + 32'(16 * i));
                b.data = bb[128*i +: 128];
                b.err  = errs[i];
                b.due  = 0;
                beat_q.push_back(b);
                e.err = e.err | errs[i];
            end
            if (vl == 2'b10)      e.wd = bb;
            else if (vl == 2'b01) e.wd = {384'b0, bb[127:0]};
            else                  e.wd = {480'b0, 32'((bb[127:0] >> (32 * addr[3:2])) & 128'hFFFF_FFFF)};
            e.vl  = vl;
            e.rd  = rd;
            e.lat = lat;
            exp_q.push_back(e);
        end
        t = 0;
        while (!bus.req_ready && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) chk("req_ready_timeout", 1'b0, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_vl    = vl;
        bus.req_rd    = rd;
        bus.req_addr  = addr;
        step();
        bus.req_valid = 1'b0;
        bus.req_vl    = 2'($urandom);
        bus.req_addr  = $urandom;
        if (vl == 2'b11) chk("bad_vl_accept", {bus.busy, bus.req_ready}, 2'b01);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0 || bus.busy) && t < 2000) begin
            step();
            t++;
        end
        if (t >= 2000) chk("idle_timeout", 1'b0, 1'b1);
        repeat (3) step();
    endtask

    function automatic logic [511:0] rnd_bundle();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [511:0] bb;
        logic [1:0]   vl;
        logic [31:0]  addr;
        logic [3:0]   errs;

        bus.req_valid = 1'b0;
        bus.req_vl    = 2'b00;
        bus.req_rd    = '0;
        bus.req_addr  = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Directed, memory always ready, zero response gap.
        do_req(2'b01, 5'd4, 32'h0000_0100,
               {384'b0, 128'h0123456789ABCDEF0123456789ABCDEF}, 4'b0, 3);
        wait_idle();
        do_req(2'b10, 5'd8, 32'h0000_2000, rnd_bundle(), 4'b0, 6);
        wait_idle();
        bb = {384'b0, 32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        do_req(2'b00, 5'd1, 32'h0000_0308, bb, 4'b0, 3);
        wait_idle();
        do_req(2'b11, 5'd2, 32'h0000_0400, rnd_bundle(), 4'b0, -1);
        repeat (10) step();

        // Random loads with stalling memory and response gaps.
        rnd_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            vl   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = (k % 8 == 3) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            errs = 4'b0;
`ifdef VLD_BUS_ERR_EN
            for (int i = 0; i < 4; i++) errs[i] = ($urandom_range(0, 9) == 0);
`endif
            do_req(vl, 5'($urandom), addr, rnd_bundle(), errs, -1);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

`ifdef VLD_BUS_ERR_EN
        do_req(2'b10, 5'd12, 32'h0000_5000, rnd_bundle(), 4'b0100, -1);
        wait_idle();
`endif

        // Reset in the middle of a 4-beat load; late responses must not write.
        do_req(2'b10, 5'd9, 32'h0000_4000, rnd_bundle(), 4'b0, -1);
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        wait_idle();

        rnd_mode = 1'b0;
        do_req(2'b01, 5'd31, 32'h0000_0110, rnd_bundle(), 4'b0, 3);
        wait_idle();

        chk("queues_empty", 32'(exp_q.size() + addr_q.size() + beat_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vec_load_unit.md
# vec_load_unit

Vector load sequencer feeding the write port of the vector/scalar register file. Accepts one load request (base address, destination register, vector length), fetches 1 or 4 128-bit beats over an in-order memory port, assembles them into a 512-bit write bundle, and issues a single-cycle register-file write. It is the upstream producer of the register file's `we`/`VL`/`wa`/`wd` inputs.

## Interface

Parameters:
- `ADDR_W`, default 32: byte address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: async active-low reset.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit can accept a request.
- `req_vl` in 2: vector length. 00 = 1 word, 01 = 4 words, 10 = 16 words, 11 = illegal.
- `req_rd` in 5: first destination register.
- `req_addr` in ADDR_W: byte address.
- `mem_req_valid` out 1: beat read request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_W: 16-byte-aligned beat address.
- `mem_rsp_valid` in 1: beat data returned, in order.
- `mem_rsp_data` in 128: beat data.
- `mem_rsp_err` in 1: beat error. Present only with `VLD_BUS_ERR_EN`.
- `rf_we` out 1: register-file write strobe.
- `rf_vl` out 2: vector length to the register file.
- `rf_wa` out 5: write address.
- `rf_wd` out 512: write data. Word i occupies bits `[32*i +: 32]`.
- `ld_err` out 1: one-cycle error pulse. Present only with `VLD_BUS_ERR_EN`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

- States: IDLE, RUN, WRITE.
- **IDLE**
  - `req_ready` = 1.
  - When `req_valid` is high, latch `vl`, `rd`, and `base = {req_addr[ADDR_W-1:4], 4'b0}`. Latch `lane = req_addr[3:2]`.
  - Set `beats` to 1 for VL 00/01 and 4 for VL 10. Clear the 512-bit buffer and both counters. Go to RUN.
  - VL 11: the request is accepted (handshake completes) and dropped. No memory traffic, no write, stay in IDLE.
  - Responses arriving in IDLE are ignored.
- **RUN**
  - `mem_req_valid` is high while `issued < beats`. `mem_req_addr = base + 16*issued`. `issued` increments on `mem_req_valid && mem_req_ready`.
  - On `mem_rsp_valid`, write the beat into `buf[128*rcvd +: 128]` and increment `rcvd`.
  - Issue and collect overlap: requests may continue while earlier responses return.
  - Responses with `rcvd == beats` are ignored as protocol violations.
  - Go to WRITE in the cycle after the last beat is captured.
- **WRITE**
  - `rf_we` = 1 for exactly one cycle, with `rf_vl = vl` and `rf_wa = rd`.
  - `rf_wd` by VL:
    - VL 10: the full buffer.
    - VL 01: beat 0 in bits [127:0], zeros above.
    - VL 00: 32-bit word `lane` of beat 0 in bits [31:0], zeros above.
  - Return to IDLE.
- The destination range (`rd` + word count) is not checked; the issuer guarantees it.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.

## Timing

- Reset values:
  - `req_ready` = 1.
  - `mem_req_valid`, `rf_we`, `ld_err`, `busy` = 0.
  - `mem_req_addr`, `rf_vl`, `rf_wa`, `rf_wd` = 0.
  - State = IDLE.
- All outputs except `req_ready` are registered. `req_ready` is decoded from the state.
- Minimum latency, with `mem_req_ready` = 1 and the response one cycle after the request:
  - Accept at cycle 0, `mem_req_valid` at cycle 1, response at cycle 2, `rf_we` at cycle 3 for 1 beat.
  - For 4 beats, `rf_we` is at cycle 6 (back-to-back issue).
- A response is never consumed in the same cycle as its request.
- `mem_req_valid`/`mem_req_addr` hold stable until accepted.
- The next request can be accepted in the cycle after WRITE.
- Reset mid-operation: return to IDLE immediately and discard the buffer. Late responses are ignored in IDLE.

## Configuration

- Macro: `VLD_BUS_ERR_EN`.
- Defined:
  - The `mem_rsp_err` and `ld_err` ports exist.
  - Any beat with `mem_rsp_err` high sets a sticky flag. Remaining beats are still issued and drained.
  - Instead of WRITE, the unit pulses `ld_err` for one cycle with no `rf_we`, then returns to IDLE.
- Undefined: the ports are absent and every load completes with a write.

## Structure

- Shared package `vec_pkg`:
  - VL encodings (`VL_1`, `VL_4`, `VL_16`, `VL_BAD`).
  - Beat-count function.
  - State enum.
  - `BEAT_W = 128`, `VREG_W = 512`.
- One sub-module, `vld_beat_buffer`: 512-bit assembly register with clear, indexed beat write, and lane-select output formatting.

## Test plan

- VL 01, addr 0x100, rd 4, beat 0x0123…CDEF -> `mem_req_addr` 0x100; `rf_we` at cycle 3 with `rf_wa` 4, `rf_vl` 01, `rf_wd[127:0]` = beat, upper bits zero.
- VL 10, addr 0x2000, rd 8, beats B0..B3 -> request addresses 0x2000/0x2010/0x2020/0x2030; `rf_wd` = {B3,B2,B1,B0}; exactly one `rf_we`.
- VL 00, addr 0x308, beat words {W3,W2,W1,W0} -> `mem_req_addr` 0x300; `rf_wd[31:0]` = W2, all other bits zero.
- VL 10 with `mem_req_ready` toggling and 0–3 cycle response gaps -> address stable while stalled; data order preserved; `busy` high until WRITE completes.
- VL 11 request -> accepted in one cycle; no `mem_req_valid` and no `rf_we` follow. Reset asserted mid-RUN -> all outputs at reset values; a late response produces no write.
- With `VLD_BUS_ERR_EN`: VL 10 with an error on beat 2 -> all 4 beats drained; one `ld_err` pulse; no `rf_we`.
